// File: rtl/minitb_ahb_pkg.sv
// Shared types for the minitb AHB arbiter: bus transfer encodings and arbiter states.
package minitb_ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    PARK,
    GRANT,
    LOCKED
  } arb_state_t;

  localparam int unsigned HOLD_W = 8;

endpackage

// File: rtl/minitb_rr_picker.sv
// Combinational round-robin find-first: first set request searching upward from ptr+1, wrapping.
module minitb_rr_picker
#(
  parameter  int unsigned NUM_MASTERS = 4,
  localparam int unsigned IW          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_MASTERS-1:0] pick_oh,
  output logic [IW-1:0]          pick_idx,
  output logic                   pick_valid
);

  logic [IW-1:0] slot;

  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    slot       = '0;
    // The pointer itself is visited last, so a current owner only wins if nobody else asks.
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      slot = IW'((32'(ptr) + i) % NUM_MASTERS);
      if (!pick_valid && req[slot]) begin
        pick_valid    = 1'b1;
        pick_idx      = slot;
        pick_oh[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minitb_ahb_arbiter.sv
// Round-robin AHB bus arbiter with hold limit and parking on DEFAULT_MASTER.
// Optional locked-transfer support when MINITB_AHB_ARB_LOCK_EN is defined.
module minitb_ahb_arbiter
  import minitb_ahb_pkg::*;
#(
  parameter  int unsigned NUM_MASTERS    = 4,
  parameter  int unsigned DEFAULT_MASTER = 0,
  parameter  int unsigned MAX_HOLD       = 8,
  localparam int unsigned IW             = $clog2(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [IW-1:0]          hmaster,
  output logic [IW-1:0]          hmaster_d,
  output logic                   hmastlock
);

  localparam logic [HOLD_W-1:0]      HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IW-1:0]          DEF_IDX  = IW'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_OH   = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;

  arb_state_t             state;
  htrans_t                trans;
  logic [IW-1:0]          grant_idx;
  logic [IW-1:0]          rr_ptr;
  logic [HOLD_W-1:0]      hold_cnt;
  logic [HOLD_W-1:0]      hold_inc;
  logic [NUM_MASTERS-1:0] win_oh;
  logic [IW-1:0]          win_idx;
  logic                   win_valid;
  logic                   arb_point;
  logic                   others_req;
  logic                   hold_hit;
  logic                   need_move;

  minitb_rr_picker #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_picker (
    .req       (hbusreq),
    .ptr       (rr_ptr),
    .pick_oh   (win_oh),
    .pick_idx  (win_idx),
    .pick_valid(win_valid)
  );

  assign trans      = htrans_t'(htrans);
  assign arb_point  = hready && (trans == IDLE || trans == NONSEQ);
  assign others_req = |(hbusreq & ~hgrant);
  // The hold decision includes the transfer completing this cycle, so a tenure is exactly MAX_HOLD NONSEQs.
  assign hold_inc   = (trans == NONSEQ && hold_cnt < HOLD_MAX) ? hold_cnt + HOLD_W'(1) : hold_cnt;
  assign hold_hit   = (hold_inc == HOLD_MAX);
  assign need_move  = !hbusreq[grant_idx] || (hold_hit && others_req);

`ifdef MINITB_AHB_ARB_LOCK_EN
  logic lock_release;
`else
  logic unused_hlock;
  assign unused_hlock = ^hlock;
  assign hmastlock    = 1'b0;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= PARK;
      hgrant    <= DEF_OH;
      grant_idx <= DEF_IDX;
      rr_ptr    <= DEF_IDX;
      hmaster   <= DEF_IDX;
      hmaster_d <= DEF_IDX;
      hold_cnt  <= '0;
`ifdef MINITB_AHB_ARB_LOCK_EN
      hmastlock    <= 1'b0;
      lock_release <= 1'b0;
`endif
    end else if (hready) begin
      hmaster   <= grant_idx;
      hmaster_d <= hmaster;
      if (arb_point) begin
        if (state == PARK) begin
          if (win_valid) begin
            state     <= GRANT;
            hgrant    <= win_oh;
            grant_idx <= win_idx;
            rr_ptr    <= win_idx;
            hold_cnt  <= '0;
          end
        end
`ifdef MINITB_AHB_ARB_LOCK_EN
        // Once hlock drops, one more transfer completes under lock before normal arbitration resumes.
        else if (state == LOCKED && !lock_release) begin
          hold_cnt <= hold_inc;
          if (!hlock[grant_idx]) lock_release <= 1'b1;
        end else if (state == GRANT && hbusreq[grant_idx] && hlock[grant_idx]) begin
          state     <= LOCKED;
          hmastlock <= 1'b1;
          hold_cnt  <= hold_inc;
        end
`endif
        else begin
`ifdef MINITB_AHB_ARB_LOCK_EN
          lock_release <= 1'b0;
          hmastlock    <= 1'b0;
`endif
          if (!win_valid) begin
            state     <= PARK;
            hgrant    <= DEF_OH;
            grant_idx <= DEF_IDX;
            hold_cnt  <= '0;
          end else if (need_move) begin
            state     <= GRANT;
            hgrant    <= win_oh;
            grant_idx <= win_idx;
            rr_ptr    <= win_idx;
            hold_cnt  <= '0;
          end else begin
            state    <= GRANT;
            hold_cnt <= hold_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_minitb_ahb_arbiter.sv
// Directed bench for minitb_ahb_arbiter; lock scenario runs when MINITB_AHB_ARB_LOCK_EN is defined.
module tb_minitb_ahb_arbiter;
  import minitb_ahb_pkg::*;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_d;
  logic       hmastlock;

  int n_pass;
  int n_fail;
  int n_total;
  int order [5];

  minitb_ahb_arbiter #(
    .NUM_MASTERS   (4),
    .DEFAULT_MASTER(0),
    .MAX_HOLD      (8)
  ) dut (
    .hclk     (hclk),
    .hresetn  (hresetn),
    .hbusreq  (hbusreq),
    .hlock    (hlock),
    .htrans   (htrans),
    .hready   (hready),
    .hgrant   (hgrant),
    .hmaster  (hmaster),
    .hmaster_d(hmaster_d),
    .hmastlock(hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hready  = 1'b1;
    tick();
    hresetn = 1'b1;
  endtask

  initial begin
    n_pass  = 0;
    n_fail  = 0;
    n_total = 0;
    order   = '{1, 2, 3, 0, 1};
    hresetn = 1'b0;
    hbusreq = '0;
    hlock   = '0;
    htrans  = IDLE;
    hready  = 1'b1;
    repeat (2) tick();
    chk("rst_grant", hgrant, 4'b0001);
    chk("rst_master", hmaster, 0);
    chk("rst_master_d", hmaster_d, 0);
    chk("rst_lock", hmastlock, 0);
    hresetn = 1'b1;

    // Parked on master 0 with no requests
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("park_grant", hgrant, 4'b0001);
      chk("park_master", hmaster, 0);
    end

    // Single request: grant, then address owner, then data owner
    hbusreq = 4'b0100;
    tick();
    chk("req2_grant", hgrant, 4'b0100);
    chk("req2_master_early", hmaster, 0);
    tick();
    chk("req2_master", hmaster, 2);
    chk("req2_master_d_early", hmaster_d, 0);
    tick();
    chk("req2_master_d", hmaster_d, 2);
    hbusreq = 4'b0000;
    tick();
    chk("req2_park", hgrant, 4'b0001);
    tick();
    chk("req2_park_master", hmaster, 0);

    // All request, continuous NONSEQ: 8-cycle tenures in order 1,2,3,0,1
    do_reset();
    hbusreq = 4'b1111;
    htrans  = NONSEQ;
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("rr_grant", hgrant, 32'(1) << order[(t - 1) / 8]);
      chk("rr_master", hmaster, (t == 1) ? 0 : order[(t - 2) / 8]);
    end

    // Owner 1 drops request while hready=0: grant frozen, then park
    htrans  = IDLE;
    hbusreq = 4'b0010;
    tick();
    chk("wait_own", hgrant, 4'b0010);
    hready  = 1'b0;
    hbusreq = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_grant", hgrant, 4'b0010);
      chk("wait_master", hmaster, 1);
    end
    hready = 1'b1;
    tick();
    chk("wait_park", hgrant, 4'b0001);

    // Hold count saturates with a lone owner; SEQ blocks handover, IDLE releases it
    hbusreq = 4'b0010;
    htrans  = NONSEQ;
    tick();
    chk("hold_take", hgrant, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_alone", hgrant, 4'b0010);
    end
    hbusreq = 4'b0110;
    htrans  = SEQ;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_seq", hgrant, 4'b0010);
    end
    htrans = IDLE;
    tick();
    chk("hold_release", hgrant, 4'b0100);

    // Owner 2 drops while hready=0 with master 1 still asking
    hbusreq = 4'b0010;
    hready  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait2_grant", hgrant, 4'b0100);
    end
    hready = 1'b1;
    tick();
    chk("wait2_next", hgrant, 4'b0010);

    // Asynchronous reset in the middle of a stalled burst
    htrans  = SEQ;
    hready  = 1'b0;
    hbusreq = 4'b1111;
    #2 hresetn = 1'b0;
    #1;
    chk("async_grant", hgrant, 4'b0001);
    chk("async_master", hmaster, 0);
    chk("async_master_d", hmaster_d, 0);
    do_reset();

`ifdef MINITB_AHB_ARB_LOCK_EN
    hbusreq = 4'b1000;
    hlock   = 4'b1000;
    htrans  = NONSEQ;
    tick();
    chk("lock_take", hgrant, 4'b1000);
    chk("lock_pre", hmastlock, 0);
    tick();
    chk("lock_on", hmastlock, 1);
    chk("lock_master", hmaster, 3);
    hbusreq = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lock_hold", hgrant, 4'b1000);
      chk("lock_flag", hmastlock, 1);
    end
    hlock = 4'b0000;
    tick();
    chk("lock_last_grant", hgrant, 4'b1000);
    chk("lock_last_flag", hmastlock, 1);
    tick();
    chk("lock_exit_grant", hgrant, 4'b0001);
    chk("lock_exit_flag", hmastlock, 0);
`else
    hbusreq = 4'b1000;
    hlock   = 4'b1111;
    htrans  = NONSEQ;
    tick();
    chk("nolock_take", hgrant, 4'b1000);
    chk("nolock_flag", hmastlock, 0);
    tick();
    chk("nolock_flag2", hmastlock, 0);
    chk("nolock_master", hmaster, 3);
    hbusreq = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("nolock_hold", hgrant, 4'b1000);
    end
    tick();
    chk("nolock_move", hgrant, 4'b0001);
    chk("nolock_flag3", hmastlock, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
